// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart transmitter between N_REQ requesters.
// Each grant becomes a two-word frame {tag, data} driven through the send_data/tx_ready handshake.
module uart_tx_scheduler #(
  parameter int          N_REQ        = 4,
  parameter logic [15:0] TAG_BASE     = 16'hA500,
  parameter int          BUSY_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0][15:0]     req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       send_data,
  output logic [1:0][15:0]           tx_nums,
  input  logic                       tx_ready,
  output logic [2:0]                 dbg_state_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  // Handshake: send_data is a one-cycle start strobe; tx_ready high means the uart is idle,
  // falls once it accepts the frame and rises again when the frame has left the wire.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_ACK       = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [15:0]       tag_q, tag_d;
  logic [15:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_pulse;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;

  // Scan from the highest offset down so the nearest requester after last_q wins.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = int'(last_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      grant_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_q;
    tag_d         = tag_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    timeout_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req && tx_ready) state_d = S_GRANT;
      end
      S_GRANT: begin
        // A request withdrawn between IDLE and GRANT simply abandons the grant.
        if (pick_found) begin
          grant_d = pick_id;
          tag_d   = TAG_BASE | 16'(pick_id);
          data_d  = req_data[pick_id];
          last_d  = pick_id;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_pulse = 1'b1;
          state_d       = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign send_data   = (state_q == S_SEND);
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_pulse;
  assign ack         = (state_q == S_ACK) ? (N_REQ'(1) << grant_q) : '0;
  assign grant_id    = grant_q;
  assign tx_nums     = {data_q, tag_q};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized frames against a round-robin model.
module tb_uart_tx_scheduler;

  localparam int          N        = 4;
  localparam int          B        = 64;
  localparam logic [15:0] TAG_BASE = 16'hA500;

  logic                 clk;
  logic                 reset_n;
  logic [N-1:0]         req;
  logic [N-1:0][15:0]   req_data;
  logic [N-1:0]         ack;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;
  logic                 send_data;
  logic [1:0][15:0]     tx_nums;
  logic                 tx_ready;
  logic [2:0]           dbg_state;

  int          n_pass     = 0;
  int          n_total    = 0;
  int          model_last = N - 1;
  logic [31:0] exp_q[$];

  uart_tx_scheduler #(
    .N_REQ        (N),
    .TAG_BASE     (TAG_BASE),
    .BUSY_TIMEOUT (B)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .send_data   (send_data),
    .tx_nums     (tx_nums),
    .tx_ready    (tx_ready),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    req      = '0;
    tx_ready = 1'b1;
    tick();
    tick();
    reset_n    = 1'b1;
    model_last = N - 1;
    tick();
  endtask

  // reference: first requester at offsets 1..N after the last served index
  function automatic int model_pick(input logic [N-1:0] r);
    model_pick = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (model_last + k) % N;
      if (r[c] && model_pick < 0) model_pick = c;
    end
  endfunction

  // driver + uart model: serves one frame starting from an idle/ack cycle with req held
  task automatic do_frame(input int dly_busy, input int len, input bit to_mode, input bit chg_data,
                          input int pulse_bit, output int lat, output int id);
    logic [31:0]  exp_word;
    logic [N-1:0] oh;
    int           k;
    int           to_k;
    bit           stable;
    bit           extra;
    id         = model_pick(req);
    model_last = id;
    exp_q.push_back({req_data[id], TAG_BASE | 16'(id)});
    lat = 0;
    while (send_data !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("send_seen", send_data, 1'b1);
    exp_word = exp_q.pop_front();
    check("tx_tag", tx_nums[0], exp_word[15:0]);
    check("tx_data", tx_nums[1], exp_word[31:16]);
    check("grant_id", grant_id, id);
    k      = 0;
    to_k   = -1;
    stable = 1'b1;
    extra  = 1'b0;
    while (k < B + 20) begin
      if (k == 0 && chg_data) req_data[id] = ~req_data[id];
      if (pulse_bit >= 0) begin
        if (k == 0) req[pulse_bit] = 1'b1;
        if (k == 1) req[pulse_bit] = 1'b0;
      end
      if (!to_mode) begin
        if (k == dly_busy)       tx_ready = 1'b0;
        if (k == dly_busy + len) tx_ready = 1'b1;
      end
      tick();
      k++;
      if (ack !== '0) break;
      if (tx_nums !== exp_word) stable = 1'b0;
      if (send_data !== 1'b0) extra = 1'b1;
      if (timeout_err === 1'b1) begin
        if (to_k < 0) to_k = k;
        else extra = 1'b1;
      end
    end
    oh     = '0;
    oh[id] = 1'b1;
    check("ack_onehot", ack, oh);
    check("ack_latency", k, to_mode ? B + 1 : dly_busy + len + 1);
    check("timeout_at", to_k, to_mode ? B : -1);
    check("tx_stable", stable, 1'b1);
    check("no_extra_pulse", extra, 1'b0);
  endtask

  initial begin
    int lat;
    int id;
    int guard;
    bit bad;
    int order[4];
    order    = '{0, 1, 3, 0};
    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    tx_ready = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_send", send_data, 1'b0);
    check("rst_ack", ack, '0);
    check("rst_grant", grant_id, '0);
    check("rst_tx_nums", tx_nums, '0);
    check("rst_timeout", timeout_err, 1'b0);
    reset_n = 1'b1;
    tick();

    // single request
    req[2]      = 1'b1;
    req_data[2] = 16'h55AA;
    do_frame(3, 4, 1'b0, 1'b0, -1, lat, id);
    check("t1_latency", lat, 2);
    check("t1_id", id, 2);
    req = '0;
    tick();
    check("t1_busy_after", busy, 1'b0);
    check("t1_ack_clear", ack, '0);

    // contention from reset
    do_reset();
    req         = 4'b1011;
    req_data[0] = 16'h0001;
    req_data[1] = 16'h0002;
    req_data[3] = 16'h0008;
    for (int f = 0; f < 4; f++) begin
      do_frame(1 + f, 2, 1'b0, 1'b0, -1, lat, id);
      check("t2_order", id, order[f]);
    end
    req = '0;
    tick();

    // withdrawn request while busy, then grant abandoned in GRANT
    req         = 4'b0001;
    req_data[0] = 16'($urandom);
    do_frame(2, 3, 1'b0, 1'b0, 1, lat, id);
    req = '0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy !== 1'b0 || send_data !== 1'b0 || ack !== '0) bad = 1'b1;
    end
    check("t3_idle", bad, 1'b0);
    req[1] = 1'b1;
    tick();
    check("t3_grant_busy", busy, 1'b1);
    req = '0;
    tick();
    check("t3_abort_idle", busy, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy !== 1'b0 || send_data !== 1'b0 || ack !== '0) bad = 1'b1;
    end
    check("t3_abort_quiet", bad, 1'b0);
    req         = 4'b0011;
    req_data[1] = 16'($urandom);
    do_frame(1, 2, 1'b0, 1'b0, -1, lat, id);
    check("t3_next_id", id, 1);

    // timeout, then normal service
    req         = 4'b0100;
    req_data[2] = 16'($urandom);
    do_frame(0, 0, 1'b1, 1'b0, -1, lat, id);
    req         = 4'b1000;
    req_data[3] = 16'($urandom);
    do_frame(1, 3, 1'b0, 1'b0, -1, lat, id);
    check("t4_after_id", id, 3);

    // data changed after grant
    req         = 4'b0010;
    req_data[1] = 16'h1234;
    do_frame(3, 4, 1'b0, 1'b1, -1, lat, id);
    check("t6_latched", tx_nums[1], 16'h1234);

    // reset during WAIT_DONE
    req         = 4'b0010;
    req_data[1] = 16'($urandom);
    guard       = 0;
    while (send_data !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("t5_send", send_data, 1'b1);
    tx_ready = 1'b0;
    tick();
    tick();
    check("t5_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_send", send_data, 1'b0);
    check("t5_rst_ack", ack, '0);
    check("t5_rst_grant", grant_id, '0);
    check("t5_rst_tx_nums", tx_nums, '0);
    check("t5_rst_timeout", timeout_err, 1'b0);
    tx_ready = 1'b1;
    bad      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    check("t5_no_ack", bad, 1'b0);
    tx_ready   = 1'b0;
    req        = 4'b1111;
    reset_n    = 1'b1;
    model_last = N - 1;
    bad        = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy !== 1'b0 || send_data !== 1'b0) bad = 1'b1;
    end
    check("t5_wait_ready", bad, 1'b0);
    tx_ready = 1'b1;
    do_frame(2, 2, 1'b0, 1'b0, -1, lat, id);
    check("t5_first_id", id, 0);
    check("t5_latency", lat, 2);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int r = 0; r < N; r++) req_data[r] = 16'($urandom);
      do_frame(int'($urandom_range(0, 6)), int'($urandom_range(2, 6)),
               ($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)), -1, lat, id);
    end
    req = '0;
    tick();
    tick();
    check("final_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
